lfsr_checker: RTL and testbench

- Receive-side companion to the 8-bit `lfsr` generator: consumes the generator's `q` word stream, self-synchronizes to it, then flags every word that departs from the expected pseudo-random sequence.
- Used on board and in simulation to prove the random source feeding spawn/placement logic is stepping correctly, and to detect dropped, repeated or corrupted words on the path between generator and consumer.
- Fully registered; one word per valid cycle.

---
 rtl/lfsr_pkg.sv | 16 +
 rtl/lfsr_checker.sv | 103 ++++++++++
 tb/tb_lfsr_checker.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR generator and its receive-side checker.
// The polynomial lives here only, so generator and checker cannot drift apart.
package lfsr_pkg;

  localparam int WIDTH = 8;

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  // Taps 7,5,4,3; 0x00 is the lock-up word and maps to itself.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Self-synchronizing checker for the lfsr word stream: hunts, verifies LOCK_COUNT
// predictions, then flywheels and counts every word that departs from the sequence.
module lfsr_checker #(
  parameter int WIDTH        = 8,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERR_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected,
  output logic [1:0]       state
);
  import lfsr_pkg::*;

  logic [3:0]       match_cnt;
  logic [3:0]       miss_cnt;
  logic             hit;
  logic             miss_hit;
  logic [3:0]       match_nxt;
  logic [3:0]       miss_nxt;
  logic [ERR_W-1:0] cnt_base;
  logic [ERR_W-1:0] err_next;

  assign hit       = (data_in == expected);
  assign miss_hit  = data_valid && (state == LOCKED) && !hit;
  assign match_nxt = match_cnt + 4'd1;
  assign miss_nxt  = miss_cnt + 4'd1;

  // Clear is applied first so a same-cycle counted mismatch lands on 1.
  always_comb begin
    cnt_base = err_clr ? '0 : err_count;
    err_next = cnt_base;
    if (miss_hit && (cnt_base != '1))
      err_next = cnt_base + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      expected  <= '0;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
    end else begin
      err_pulse <= miss_hit;
      err_count <= err_next;
      if (data_valid) begin
        case (state)
          HUNT: begin
            if (data_in != '0) begin
              expected  <= lfsr_next(data_in);
              match_cnt <= 4'd0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (hit) begin
              expected  <= lfsr_next(expected);
              match_cnt <= match_nxt;
              if (match_nxt == 4'(LOCK_COUNT)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= 4'd0;
              end
            end else if (data_in != '0) begin
              expected  <= lfsr_next(data_in);
              match_cnt <= 4'd0;
            end else begin
              state <= HUNT;
            end
          end
          LOCKED: begin
            // Flywheel: keep stepping the prediction even across bad words.
            expected <= lfsr_next(expected);
            if (hit) begin
              miss_cnt <= 4'd0;
            end else begin
              miss_cnt <= miss_nxt;
              if (miss_nxt == 4'(UNLOCK_COUNT)) begin
                state  <= HUNT;
                locked <= 1'b0;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scenario bench for lfsr_checker against a behavioural model of the lock/flywheel rules.
// The error counter is built 8 bits wide here so saturation is reachable in a short run.
module tb_lfsr_checker;

  localparam int LOCK   = 4;
  localparam int UNLOCK = 3;
  localparam int EW     = 8;
  localparam int CMAX   = (1 << EW) - 1;

  logic          clk;
  logic          rst;
  logic [7:0]    data_in;
  logic          data_valid;
  logic          err_clr;
  logic          locked;
  logic          err_pulse;
  logic [EW-1:0] err_count;
  logic [7:0]    expected;
  logic [1:0]    state;

  lfsr_checker #(.WIDTH(8), .LOCK_COUNT(LOCK), .UNLOCK_COUNT(UNLOCK), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .err_clr(err_clr),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .expected(expected),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model
  int         m_state;
  int         m_match;
  int         m_miss;
  int         m_cnt;
  logic       m_locked;
  logic       m_pulse;
  logic [7:0] m_exp;
  logic [7:0] g;

  function automatic logic [7:0] gnext(input logic [7:0] x);
    int fb;
    fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
    return 8'(((int'(x) * 2) % 256) + fb);
  endfunction

  function automatic logic [19:0] mexp();
    return {2'(m_state), m_locked, m_pulse, 8'(m_cnt), m_exp};
  endfunction

  task automatic model_reset();
    m_state = 0; m_match = 0; m_miss = 0; m_cnt = 0;
    m_locked = 1'b0; m_pulse = 1'b0; m_exp = 8'h00;
  endtask

  task automatic model_step(input logic [7:0] d, input logic v, input logic c);
    logic ok;
    m_pulse = 1'b0;
    if (c) m_cnt = 0;
    if (v) begin
      if (m_state == 0) begin
        if (d != 0) begin m_exp = gnext(d); m_match = 0; m_state = 1; end
      end else if (m_state == 1) begin
        if (d == m_exp) begin
          m_match++; m_exp = gnext(m_exp);
          if (m_match == LOCK) begin m_state = 2; m_locked = 1'b1; m_miss = 0; end
        end else if (d != 0) begin
          m_exp = gnext(d); m_match = 0;
        end else begin
          m_state = 0;
        end
      end else begin
        ok = (d == m_exp);
        m_exp = gnext(m_exp);
        if (ok) m_miss = 0;
        else begin
          m_pulse = 1'b1;
          if (m_cnt < CMAX) m_cnt++;
          m_miss++;
          if (m_miss == UNLOCK) begin m_state = 0; m_locked = 1'b0; end
        end
      end
    end
  endtask

  task automatic tick(input logic [7:0] d, input logic v, input logic c);
    data_in = d; data_valid = v; err_clr = c;
    @(posedge clk);
    model_step(d, v, c);
    #1;
    data_valid = 1'b0; err_clr = 1'b0;
  endtask

  // Feed the next generator word and step the generator.
  task automatic feed();
    tick(g, 1'b1, 1'b0);
    g = gnext(g);
  endtask

  task automatic test_reset();
    rst = 1'b1; data_in = 8'h00; data_valid = 1'b0; err_clr = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({state, locked, err_pulse, err_count, expected} !== mexp()) begin
      n_bad++; $display("FAIL reset_async: got %h want %h", {state, locked, err_pulse, err_count, expected}, mexp());
    end
    data_in = 8'h5A; data_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({state, locked, err_pulse, err_count, expected} !== 20'h0) begin
      n_bad++; $display("FAIL reset_held: got %h want 0", {state, locked, err_pulse, err_count, expected});
    end
    data_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_lock();
    g = 8'h03;
    feed();
    n_cmp++;
    if (state !== 2'd1 || expected !== 8'h06) begin
      n_bad++; $display("FAIL lock_verify: got state %0d exp %h want 1 06", state, expected);
    end
    for (int i = 0; i < LOCK; i++) begin
      n_cmp++;
      if (locked !== 1'b0) begin
        n_bad++; $display("FAIL lock_early: got locked %b want 0 at word %0d", locked, i);
      end
      feed();
    end
    n_cmp++;
    if ({state, locked, err_count, expected} !== {2'd2, 1'b1, 8'h00, 8'h64}) begin
      n_bad++; $display("FAIL lock_done: got %h want %h", {state, locked, err_count, expected}, {2'd2, 1'b1, 8'h00, 8'h64});
    end
  endtask

  task automatic test_single_error();
    tick(g ^ 8'h01, 1'b1, 1'b0);
    g = gnext(g);
    n_cmp++;
    if ({err_pulse, err_count, locked} !== {1'b1, 8'd1, 1'b1}) begin
      n_bad++; $display("FAIL single_err: got %h want %h", {err_pulse, err_count, locked}, {1'b1, 8'd1, 1'b1});
    end
    tick(8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (err_pulse !== 1'b0 || err_count !== 8'd1) begin
      n_bad++; $display("FAIL pulse_width: got pulse %b cnt %0d want 0 1", err_pulse, err_count);
    end
    // Two more bad words only unlock if the intervening good word failed to clear the miss count.
    feed();
    tick(g ^ 8'h80, 1'b1, 1'b0); g = gnext(g);
    tick(g ^ 8'h80, 1'b1, 1'b0); g = gnext(g);
    n_cmp++;
    if ({state, locked, err_count} !== {2'd2, 1'b1, 8'd3} || mexp() !== {state, locked, err_pulse, err_count, expected}) begin
      n_bad++; $display("FAIL miss_clear: got %h want %h", {state, locked, err_pulse, err_count, expected}, mexp());
    end
    feed();
  endtask

  task automatic test_drop();
    int base;
    base = m_cnt;
    repeat (3) g = gnext(g);
    for (int i = 0; i < UNLOCK; i++) feed();
    n_cmp++;
    if ({locked, state} !== {1'b0, 2'd0} || int'(err_count) != base + 3) begin
      n_bad++; $display("FAIL drop_unlock: got locked %b state %0d cnt %0d want 0 0 %0d", locked, state, err_count, base + 3);
    end
    for (int i = 0; i < LOCK; i++) feed();
    n_cmp++;
    if (locked !== 1'b0) begin
      n_bad++; $display("FAIL relock_early: got locked %b want 0", locked);
    end
    feed();
    n_cmp++;
    if (locked !== 1'b1 || {state, locked, err_pulse, err_count, expected} !== mexp()) begin
      n_bad++; $display("FAIL relock: got %h want %h", {state, locked, err_pulse, err_count, expected}, mexp());
    end
  endtask

  task automatic test_zero();
    rst = 1'b0; #1; rst = 1'b1; model_reset();
    repeat (10) tick(8'h00, 1'b1, 1'b0);
    n_cmp++;
    if ({state, locked, err_count} !== 11'h0) begin
      n_bad++; $display("FAIL zero_hunt: got state %0d locked %b cnt %0d want 0 0 0", state, locked, err_count);
    end
    g = 8'hA7;
    repeat (LOCK + 1) feed();
    tick(8'h00, 1'b1, 1'b0); g = gnext(g);
    n_cmp++;
    if ({locked, err_pulse, err_count} !== {1'b1, 1'b1, 8'd1}) begin
      n_bad++; $display("FAIL zero_locked: got %h want %h", {locked, err_pulse, err_count}, {1'b1, 1'b1, 8'd1});
    end
  endtask

  task automatic test_saturate();
    int guard;
    guard = 0;
    while (m_cnt < CMAX && guard < 600) begin
      tick(g ^ 8'h01, 1'b1, 1'b0); g = gnext(g);
      feed();
      guard++;
    end
    n_cmp++;
    if (err_count !== 8'hFF || locked !== 1'b1) begin
      n_bad++; $display("FAIL sat_reach: got cnt %h locked %b want ff 1", err_count, locked);
    end
    tick(g ^ 8'h01, 1'b1, 1'b0); g = gnext(g);
    n_cmp++;
    if ({err_pulse, err_count} !== {1'b1, 8'hFF}) begin
      n_bad++; $display("FAIL sat_hold: got pulse %b cnt %h want 1 ff", err_pulse, err_count);
    end
    tick(g ^ 8'h01, 1'b1, 1'b1); g = gnext(g);
    n_cmp++;
    if ({err_pulse, err_count} !== {1'b1, 8'd1}) begin
      n_bad++; $display("FAIL clr_and_err: got pulse %b cnt %h want 1 01", err_pulse, err_count);
    end
    tick(8'h00, 1'b0, 1'b1);
    n_cmp++;
    if (err_count !== 8'd0 || locked !== m_locked) begin
      n_bad++; $display("FAIL clr_only: got cnt %h locked %b want 00 %b", err_count, locked, m_locked);
    end
  endtask

  task automatic test_async_reset();
    g = 8'h3C;
    feed();
    #3 rst = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({state, locked, err_pulse, err_count, expected} !== mexp()) begin
      n_bad++; $display("FAIL arst_verify: got %h want %h", {state, locked, err_pulse, err_count, expected}, mexp());
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (LOCK + 1) feed();
    tick(g ^ 8'h02, 1'b1, 1'b0); g = gnext(g);
    n_cmp++;
    if (locked !== 1'b1 || err_count !== 8'd1) begin
      n_bad++; $display("FAIL arst_prelock: got locked %b cnt %0d want 1 1", locked, err_count);
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({state, locked, err_pulse, err_count, expected} !== 20'h0) begin
      n_bad++; $display("FAIL arst_locked: got %h want 0", {state, locked, err_pulse, err_count, expected});
    end
    @(posedge clk); #1 rst = 1'b1;
    feed();
    n_cmp++;
    if (state !== 2'd1 || expected !== g) begin
      n_bad++; $display("FAIL arst_reacq: got state %0d exp %h want 1 %h", state, expected, g);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       v, c;
    int         r;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 49) == 0);
      r = $urandom_range(0, 99);
      if (r < 4) g = gnext(g);
      if (r == 99) g = 8'($urandom_range(1, 255));
      d = g;
      if (r >= 4 && r < 9) d = 8'($urandom);
      if (r >= 9 && r < 11) d = 8'h00;
      tick(d, v, c);
      if (v) g = gnext(g);
      n_cmp++;
      if ({state, locked, err_pulse, err_count, expected} !== mexp()) begin
        n_bad++; $display("FAIL random[%0d]: got %h want %h", i, {state, locked, err_pulse, err_count, expected}, mexp());
      end
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_lock();
    test_single_error();
    test_drop();
    test_zero();
    test_saturate();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
